// File: rtl/line_mem_pkg.sv
// -----------------------------------------------------------------------------
// line_mem_pkg
// Shared types and address helpers for the line-granular memory.
//   port_state_t : read-port FSM state encoding (IDLE, WAIT, VALID)
//   line_idx     : byte address -> line index (offset bits dropped)
//   in_range     : true when an address falls inside [base, base + span)
// -----------------------------------------------------------------------------
package line_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } port_state_t;

  typedef logic [63:0] addr64_t;

  // The result wraps for addresses below base; callers qualify with in_range.
  function automatic addr64_t line_idx(input addr64_t addr, input addr64_t base,
                                       input int unsigned off_bits);
    return (addr - base) >> off_bits;
  endfunction

  function automatic logic in_range(input addr64_t addr, input addr64_t base,
                                    input addr64_t span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/line_mem_if.sv
// -----------------------------------------------------------------------------
// line_mem_if
// The hart's two bus ports towards the line memory.
//   Instruction port : b_addr_i, b_rd_i -> b_data_i, b_dv_i, b_err_i
//   Data port        : b_addr, b_rd     -> b_data_in, b_dv, b_err
//                      b_addr, b_wr, b_data_out (line write)
//   master : the hart side, slave : the memory side.
// -----------------------------------------------------------------------------
interface line_mem_if #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 1024
);

  logic [ADDR_W-1:0] b_addr_i;
  logic              b_rd_i;
  logic [LINE_W-1:0] b_data_i;
  logic              b_dv_i;
  logic              b_err_i;

  logic [ADDR_W-1:0] b_addr;
  logic              b_rd;
  logic [LINE_W-1:0] b_data_in;
  logic              b_dv;
  logic              b_err;
  logic [LINE_W-1:0] b_data_out;
  logic              b_wr;

  modport master (
    output b_addr_i, b_rd_i, b_addr, b_rd, b_data_out, b_wr,
    input  b_data_i, b_dv_i, b_err_i, b_data_in, b_dv, b_err
  );

  modport slave (
    input  b_addr_i, b_rd_i, b_addr, b_rd, b_data_out, b_wr,
    output b_data_i, b_dv_i, b_err_i, b_data_in, b_dv, b_err
  );

endinterface

// File: rtl/line_mem_port.sv
// -----------------------------------------------------------------------------
// line_mem_port
// One read port: IDLE/WAIT/VALID FSM, latency counter, response snapshot and
// write-first forwarding from the shared write bus.
//   clk, rst          : clock, synchronous active-high reset
//   rd, addr          : read request (level) and byte address
//   rd_idx            : line index presented to the array
//   mem_line          : array contents at rd_idx (combinational)
//   wr, wr_addr, wr_data : shared write bus, used only for forwarding
//   dv, err, data     : registered response; data is 0 outside the valid cycle
// -----------------------------------------------------------------------------
module line_mem_port
  import line_mem_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter int                LINE_W    = 1024,
  parameter int                DEPTH     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
  parameter int                LATENCY   = 4,
  parameter int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [LINE_W-1:0] mem_line,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  output logic              dv,
  output logic              err,
  output logic [LINE_W-1:0] data
);

  localparam int          OFF_W  = $clog2(LINE_W / 8);
  localparam int          CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [63:0] BASE64 = 64'(BASE_ADDR);
  localparam logic [63:0] SPAN   = 64'(DEPTH) * 64'(LINE_W / 8);

  // Legacy-style state constants, encoded from port_state_t.
  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_WAIT  = 2'(WAIT);
  localparam logic [1:0] S_VALID = 2'(VALID);

  logic [1:0]        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LINE_W-1:0] line_q;
  logic              err_q;
  logic              rd_ok;
  logic              fwd;

  assign rd_idx = IDX_W'(line_idx(64'(addr), BASE64, OFF_W));
  assign rd_ok  = in_range(64'(addr), BASE64, SPAN);
  // A write landing on the line being accepted wins over the array contents.
  assign fwd    = wr && in_range(64'(wr_addr), BASE64, SPAN) &&
                  (IDX_W'(line_idx(64'(wr_addr), BASE64, OFF_W)) == rd_idx);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
      dv      <= 1'b0;
      err     <= 1'b0;
      data    <= '0;
    end else begin
      // Response outputs are registered off the VALID state, so the bus sees
      // dv for exactly one cycle, LATENCY edges after acceptance.
      dv   <= (state_q == S_VALID);
      err  <= (state_q == S_VALID) && err_q;
      data <= (state_q == S_VALID) ? line_q : '0;

      case (state_q)
        S_IDLE: begin
          if (rd) begin
            // Snapshot taken here; later writes to this line do not affect it.
            line_q  <= !rd_ok ? '0 : (fwd ? wr_data : mem_line);
            err_q   <= !rd_ok;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= (LATENCY == 1) ? S_VALID : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= S_VALID;
        end
        S_VALID: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/line_mem.sv
// -----------------------------------------------------------------------------
// line_mem
// Line-granular memory serving the hart's instruction and data ports with a
// fixed, configurable latency. Byte i of a line is bits [8i+7:8i].
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset (FSMs and outputs; contents retained)
//   bus  : line_mem_if slave modport (instruction read port, data read/write)
// Out-of-range reads return a zero line with err set; out-of-range writes and
// writes coincident with rst are dropped.
// -----------------------------------------------------------------------------
module line_mem
  import line_mem_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter int                LINE_W    = 1024,
  parameter int                DEPTH     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
  parameter int                LATENCY   = 4,
  parameter string             INIT_FILE = ""
) (
  input logic       clk,
  input logic       rst,
  line_mem_if.slave bus
);

  localparam int          NB     = LINE_W / 8;
  localparam int          OFF_W  = $clog2(NB);
  localparam int          IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] BASE64 = 64'(BASE_ADDR);
  localparam logic [63:0] SPAN   = 64'(DEPTH) * 64'(NB);

  // Byte-wide storage, one entry per byte of every line.
  logic [7:0] mem [DEPTH*NB];

  logic [IDX_W-1:0]  idx_i, idx_d, wr_idx;
  logic [LINE_W-1:0] line_i, line_d;
  logic              wr_en;

  // NOTE: every output of this block gets a default before the loop so no
  // latch can be inferred.
  always_comb begin
    line_i = '0;
    line_d = '0;
    for (int i = 0; i < NB; i++) begin
      line_i[8*i +: 8] = mem[{idx_i, OFF_W'(i)}];
      line_d[8*i +: 8] = mem[{idx_d, OFF_W'(i)}];
    end
  end

  assign wr_en  = bus.b_wr && in_range(64'(bus.b_addr), BASE64, SPAN);
  assign wr_idx = IDX_W'(line_idx(64'(bus.b_addr), BASE64, OFF_W));

  // NOTE: the array is deliberately not reset: contents survive rst and a
  // resettable RAM would not map onto block memory.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int i = 0; i < NB; i++) mem[{wr_idx, OFF_W'(i)}] <= bus.b_data_out[8*i +: 8];
    end
  end

  line_mem_port #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH(DEPTH),
    .BASE_ADDR(BASE_ADDR), .LATENCY(LATENCY), .IDX_W(IDX_W)
  ) u_port_i (
    .clk     (clk),
    .rst     (rst),
    .rd      (bus.b_rd_i),
    .addr    (bus.b_addr_i),
    .rd_idx  (idx_i),
    .mem_line(line_i),
    .wr      (bus.b_wr),
    .wr_addr (bus.b_addr),
    .wr_data (bus.b_data_out),
    .dv      (bus.b_dv_i),
    .err     (bus.b_err_i),
    .data    (bus.b_data_i)
  );

  line_mem_port #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH(DEPTH),
    .BASE_ADDR(BASE_ADDR), .LATENCY(LATENCY), .IDX_W(IDX_W)
  ) u_port_d (
    .clk     (clk),
    .rst     (rst),
    .rd      (bus.b_rd),
    .addr    (bus.b_addr),
    .rd_idx  (idx_d),
    .mem_line(line_d),
    .wr      (bus.b_wr),
    .wr_addr (bus.b_addr),
    .wr_data (bus.b_data_out),
    .dv      (bus.b_dv),
    .err     (bus.b_err),
    .data    (bus.b_data_in)
  );

endmodule

// File: tb/tb_line_mem.sv
// -----------------------------------------------------------------------------
// tb_line_mem
// Directed bench for line_mem. Three instances (LATENCY 1, 4, 7) share one set
// of stimulus; directed checks use the LATENCY=4 instance, the back-to-back
// check covers all three, both ports concurrently.
// -----------------------------------------------------------------------------
module tb_line_mem;

  typedef logic [1023:0] line_t;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] addr_i = '0, addr_d = '0;
  logic        rd_i = 1'b0, rd_d = 1'b0, wr = 1'b0;
  line_t       wdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  line_mem_if #(.ADDR_W(64), .LINE_W(1024)) if1 (), if4 (), if7 ();

  assign if1.b_addr_i = addr_i;  assign if4.b_addr_i = addr_i;  assign if7.b_addr_i = addr_i;
  assign if1.b_rd_i   = rd_i;    assign if4.b_rd_i   = rd_i;    assign if7.b_rd_i   = rd_i;
  assign if1.b_addr   = addr_d;  assign if4.b_addr   = addr_d;  assign if7.b_addr   = addr_d;
  assign if1.b_rd     = rd_d;    assign if4.b_rd     = rd_d;    assign if7.b_rd     = rd_d;
  assign if1.b_data_out = wdata; assign if4.b_data_out = wdata; assign if7.b_data_out = wdata;
  assign if1.b_wr     = wr;      assign if4.b_wr     = wr;      assign if7.b_wr     = wr;

  line_mem #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  line_mem #(.LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  line_mem #(.LATENCY(7)) dut7 (.clk(clk), .rst(rst), .bus(if7.slave));

  task automatic check(input string tag, input line_t got, input line_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (low 256 bits)", tag, got[255:0], exp[255:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic line_t fill(input logic [7:0] b);
    return {128{b}};
  endfunction

  function automatic line_t ramp();
    line_t l;
    for (int i = 0; i < 128; i++) l[8*i +: 8] = 8'(i + 1);
    return l;
  endfunction

  task automatic do_write(input logic [63:0] a, input line_t d);
    addr_d = a; wdata = d; wr = 1'b1;
    step();
    wr = 1'b0;
  endtask

  // Read on the LATENCY=4 instance. lat = edges from acceptance to dv
  // visible (-1 on timeout). Optional write issued wr_at edges after acceptance.
  task automatic do_read(input bit dport, input logic [63:0] a, input int wr_at,
                         input logic [63:0] wa, input line_t wd,
                         output line_t line, output logic e, output int lat);
    bit seen = 1'b0;
    lat = -1; line = '0; e = 1'b0;
    if (dport) begin rd_d = 1'b1; addr_d = a; end
    else       begin rd_i = 1'b1; addr_i = a; end
    for (int k = 0; k < 20 && !seen; k++) begin
      if (k == wr_at) begin addr_d = wa; wdata = wd; wr = 1'b1; end
      step();
      wr = 1'b0;
      if (dport ? if4.b_dv : if4.b_dv_i) begin
        seen = 1'b1;
        lat  = k;
        line = dport ? if4.b_data_in : if4.b_data_i;
        e    = dport ? if4.b_err : if4.b_err_i;
      end
    end
    rd_i = 1'b0; rd_d = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    line_t line;
    logic  e;
    int    lat;
    bit    any_dv;
    logic  dvs [6];
    line_t dat [6];
    line_t expd [6];
    int    lt [6];
    int    last [6];
    int    cnt [6];

    // Reset state
    repeat (3) step();
    check("rst_dv_i", line_t'(if4.b_dv_i), '0);
    check("rst_err_i", line_t'(if4.b_err_i), '0);
    check("rst_data_i", if4.b_data_i, '0);
    check("rst_dv", line_t'(if4.b_dv), '0);
    check("rst_err", line_t'(if4.b_err), '0);
    check("rst_data_in", if4.b_data_in, '0);
    rst = 1'b0;
    step();

    // Image load through the write port
    do_write(BASE, ramp());
    do_write(BASE + 64'd128, fill(8'h11));
    do_write(BASE + 64'd31*128, fill(8'h3C));

    // Program fetch
    do_read(1'b0, BASE, -1, '0, '0, line, e, lat);
    check("fetch_lat", line_t'(lat), 4);
    check("fetch_byte0", line_t'(line[7:0]), 8'h01);
    check("fetch_line", line, ramp());
    check("fetch_err", line_t'(e), '0);
    step();
    check("fetch_dv_pulse", line_t'(if4.b_dv_i), '0);
    check("fetch_data_idle", if4.b_data_i, '0);

    // Write-first on the instruction port
    do_read(1'b0, BASE + 64'd128, 0, BASE + 64'd128, fill(8'hA5), line, e, lat);
    check("wf_line", line, fill(8'hA5));
    check("wf_lat", line_t'(lat), 4);
    step();

    // Read snapshot on the data port
    do_read(1'b1, BASE, 2, BASE, fill(8'hFF), line, e, lat);
    check("snap_old", line, ramp());
    step();
    do_read(1'b1, BASE, -1, '0, '0, line, e, lat);
    check("snap_new", line, fill(8'hFF));
    step();

    // Out of range, below and above
    do_read(1'b1, 64'h7FFF_FF80, -1, '0, '0, line, e, lat);
    check("oor_lo_err", line_t'(e), 1);
    check("oor_lo_line", line, '0);
    check("oor_lo_lat", line_t'(lat), 4);
    step();
    check("oor_err_clear", line_t'(if4.b_err), '0);
    do_read(1'b1, BASE + 64'd4096, -1, '0, '0, line, e, lat);
    check("oor_hi_err", line_t'(e), 1);
    check("oor_hi_line", line, '0);
    step();
    do_write(64'h7FFF_FF80, fill(8'hEE));
    do_write(BASE + 64'd4096, fill(8'hEE));
    do_read(1'b1, BASE + 64'd31*128 + 64'd5, -1, '0, '0, line, e, lat);
    check("oor_wr_line31", line, fill(8'h3C));
    check("offset_err", line_t'(e), '0);
    step();
    do_read(1'b1, BASE, -1, '0, '0, line, e, lat);
    check("oor_wr_line0", line, fill(8'hFF));
    step();

    // Reset mid-request, with a write coincident with reset
    rd_i = 1'b1; addr_i = BASE + 64'd128;
    step();
    step();
    rst = 1'b1; rd_i = 1'b0;
    addr_d = BASE + 64'd128; wdata = '0; wr = 1'b1;
    step();
    wr = 1'b0;
    check("midrst_dv_i", line_t'(if4.b_dv_i), '0);
    check("midrst_data_i", if4.b_data_i, '0);
    step();
    rst = 1'b0;
    any_dv = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (if4.b_dv_i) any_dv = 1'b1;
    end
    check("midrst_no_dv", line_t'(any_dv), '0);
    do_read(1'b0, BASE + 64'd128, -1, '0, '0, line, e, lat);
    check("midrst_mem_kept", line, fill(8'hA5));
    check("midrst_lat", line_t'(lat), 4);
    step();

    // Back-to-back, both ports, LATENCY 1/4/7
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    rd_i = 1'b1; addr_i = BASE;
    rd_d = 1'b1; addr_d = BASE + 64'd128;
    lt = '{1, 1, 4, 4, 7, 7};
    for (int j = 0; j < 6; j++) begin
      last[j] = 0;
      cnt[j]  = 0;
      expd[j] = (j % 2 == 0) ? fill(8'hFF) : fill(8'hA5);
    end
    for (int c = 1; c <= 24; c++) begin
      step();
      dvs[0] = if1.b_dv_i; dat[0] = if1.b_data_i;
      dvs[1] = if1.b_dv;   dat[1] = if1.b_data_in;
      dvs[2] = if4.b_dv_i; dat[2] = if4.b_data_i;
      dvs[3] = if4.b_dv;   dat[3] = if4.b_data_in;
      dvs[4] = if7.b_dv_i; dat[4] = if7.b_data_i;
      dvs[5] = if7.b_dv;   dat[5] = if7.b_data_in;
      for (int j = 0; j < 6; j++) begin
        if (dvs[j]) begin
          check($sformatf("b2b_gap_L%0d_p%0d", lt[j], j % 2), line_t'(c - last[j]), line_t'(lt[j] + 1));
          check($sformatf("b2b_data_L%0d_p%0d", lt[j], j % 2), dat[j], expd[j]);
          last[j] = c;
          cnt[j]++;
        end
      end
    end
    rd_i = 1'b0; rd_d = 1'b0;
    for (int j = 0; j < 6; j++)
      check($sformatf("b2b_count_L%0d_p%0d", lt[j], j % 2), line_t'(cnt[j]), line_t'(24 / (lt[j] + 1)));
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
